// File: rtl/iq_avg_pkg.sv
// iq_avg_pkg: shared types and constants for the IQ block averager.
package iq_avg_pkg;

    typedef enum logic {IDLE, ACCUM} state_e;

    function automatic int shift_w(input int abits);
        return $clog2(abits + 1);
    endfunction

    function automatic int lane_lo(input int k, input int nbits);
        return k * nbits;
    endfunction

    function automatic int sat_hi(input int nbits);
        return (1 << (nbits - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int nbits);
        return -(1 << (nbits - 1));
    endfunction

endpackage

// File: rtl/iq_block_averager_if.sv
// iq_block_averager_if: sample input and result output handshake bundle.
interface iq_block_averager_if #(
    parameter int NBITS = 16,
    parameter int NCH   = 2
);
    logic                  in_valid;
    logic [NCH*NBITS-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*NBITS-1:0]  out_data;

    modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/iq_avg_scale.sv
// iq_avg_scale: one lane of arithmetic right shift and signed saturation.
// IQAVG_ROUND_EN adds half an LSB before the shift (round half up).
module iq_avg_scale import iq_avg_pkg::*; #(
    parameter int NBITS = 16,
    parameter int ABITS = 9,
    parameter int SW    = shift_w(ABITS)
) (
    input  logic signed [NBITS+ABITS-1:0] sum_i,
    input  logic [SW-1:0]                 shift_i,
    output logic [NBITS-1:0]              avg_o
);
    localparam int W = NBITS + ABITS;
    localparam logic signed [W:0] HI = (W+1)'(sat_hi(NBITS));
    localparam logic signed [W:0] LO = (W+1)'(sat_lo(NBITS));

    logic signed [W:0] ext, shr;

    always_comb begin
`ifdef IQAVG_ROUND_EN
        ext = {sum_i[W-1], sum_i} + ((shift_i == '0) ? '0 : ((W+1)'(1) << (shift_i - 1'b1)));
`else
        ext = {sum_i[W-1], sum_i};
`endif
        shr = ext >>> shift_i;
        avg_o = (shr > HI) ? HI[NBITS-1:0] : (shr < LO) ? LO[NBITS-1:0] : shr[NBITS-1:0];
    end
endmodule

// File: rtl/iq_block_averager.sv
// iq_block_averager: per-lane block sum, scale and saturate with a valid/ready result.
// Define IQAVG_ROUND_EN for rounding instead of truncation in the scaler.
module iq_block_averager import iq_avg_pkg::*; #(
    parameter int NBITS = 16,
    parameter int NCH   = 2,
    parameter int ABITS = 9,
    parameter int CBITS = 4,
    parameter int SW    = shift_w(ABITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ABITS:0]    avg_len,
    input  logic [SW-1:0]     avg_shift,
    iq_block_averager_if.slave bus,
    output logic [CBITS-1:0]  block_count,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int W = NBITS + ABITS;

    state_e state_q, state_d;
    logic accept, clr, first, last, load;
    logic [ABITS:0] cnt_q, len_q, len_in, len_cur;
    logic [SW-1:0] shf_q, shf_in, shf_cur, res_shf_q;
    logic [NCH-1:0][W-1:0] acc_q, sum, res_q;
    logic res_v_q, scl_v_q, out_v_q, out_v_d, ovr_q, ovr_d;
    logic [NCH*NBITS-1:0] scaled, scl_q, out_q;
    logic [CBITS-1:0] bc_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb state_d = enable ? ACCUM : IDLE;

    always_comb begin
        accept = enable && bus.in_valid;
        clr    = (state_q == ACCUM) && !enable;
    end

    // Length and shift come straight from the ports on the first sample of a block.
    assign first   = cnt_q == '0;
    assign len_in  = (avg_len == '0) ? (ABITS+1)'(1) : avg_len;
    assign shf_in  = (avg_shift > SW'(ABITS)) ? SW'(ABITS) : avg_shift;
    assign len_cur = first ? len_in : len_q;
    assign shf_cur = first ? shf_in : shf_q;
    assign last    = accept && (cnt_q == len_cur - 1'b1);

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign sum[k] = acc_q[k] + W'($signed(bus.in_data[lane_lo(k, NBITS) +: NBITS]));
        iq_avg_scale #(.NBITS(NBITS), .ABITS(ABITS), .SW(SW)) u_scale (
            .sum_i   ($signed(res_q[k])),
            .shift_i (res_shf_q),
            .avg_o   (scaled[lane_lo(k, NBITS) +: NBITS])
        );
    end

    assign load    = scl_v_q && (!out_v_q || bus.out_ready);
    assign out_v_d = load || (out_v_q && !bus.out_ready);
    assign ovr_d   = (scl_v_q && !load) || (ovr_q && !overrun_clr);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            shf_q     <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_shf_q <= '0;
            res_v_q   <= 1'b0;
            scl_q     <= '0;
            scl_v_q   <= 1'b0;
            out_q     <= '0;
            out_v_q   <= 1'b0;
            ovr_q     <= 1'b0;
            bc_q      <= '0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (accept) begin
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                acc_q <= last ? '0 : sum;
                if (first) begin
                    len_q <= len_in;
                    shf_q <= shf_in;
                end
            end
            res_v_q <= last;
            if (last) begin
                res_q     <= sum;
                res_shf_q <= shf_cur;
                bc_q      <= bc_q + 1'b1;
            end
            scl_v_q <= res_v_q;
            if (res_v_q) scl_q <= scaled;
            if (load) out_q <= scl_q;
            out_v_q <= out_v_d;
            ovr_q   <= ovr_d;
        end

    assign bus.out_valid = out_v_q;
    assign bus.out_data  = out_q;
    assign block_count   = bc_q;
    assign overrun       = ovr_q;
endmodule

// File: tb/tb_iq_block_averager.sv
// tb_iq_block_averager: directed scoreboard bench for iq_block_averager (NCH=2, NBITS=16, ABITS=4).
module tb_iq_block_averager;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, overrun_clr = 1'b0, overrun;
    logic [4:0] avg_len = 5'd4;
    logic [2:0] avg_shift = 3'd0;
    logic [3:0] block_count;
    logic [3:0] exp_bc = 4'd0;
    logic [31:0] exp_q[$];
    longint s_i = 0, s_q = 0;
    int total = 0, bad = 0;

    iq_block_averager_if #(.NBITS(16), .NCH(2)) bus ();

    iq_block_averager #(.NBITS(16), .NCH(2), .ABITS(4), .CBITS(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .avg_len(avg_len), .avg_shift(avg_shift),
        .bus(bus), .block_count(block_count), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdl(input longint s, input int sh);
        longint v;
        v = s;
`ifdef IQAVG_ROUND_EN
        if (sh > 0) v += longint'(1) << (sh - 1);
`endif
        v = v >>> sh;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q);
        bus.in_valid = 1'b1;
        bus.in_data  = {q, i};
        s_i += longint'($signed(i));
        s_q += longint'($signed(q));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic push(input int sh);
        exp_q.push_back({mdl(s_q, sh), mdl(s_i, sh)});
        s_i = 0;
        s_q = 0;
        exp_bc++;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain: observed left=%0d expected=0", exp_q.size());
        end
    endtask

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_out: observed=%h expected=none", bus.out_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                assert (bus.out_data === e) else begin
                    bad++;
                    $error("FAIL out_data: observed=%h expected=%h", bus.out_data, e);
                end
            end
        end

    initial begin
        logic [15:0] ri, rq;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_bc", 32'(block_count), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // basic average and output latency
        enable = 1'b1; avg_len = 5'd4; avg_shift = 3'd2;
        send(16'd1, -16'sd4); send(16'd2, -16'sd4); send(16'd3, -16'sd4); send(16'd4, -16'sd4);
        push(2);
        @(posedge clk); #1;
        chk("lat_edge1", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(bus.out_valid), 32'd1);
        drain();
        chk("bc_t1", 32'(block_count), 32'(exp_bc));
        // saturation both rails
        avg_shift = 3'd0;
        repeat (4) send(16'h7FFF, 16'h8000);
        push(0);
        drain();
        // len 0 behaves as 1: pass-through
        avg_len = 5'd0;
        for (int n = 0; n < 10; n++) begin
            ri = 16'($urandom);
            rq = 16'($urandom);
            send(ri, rq);
            push(0);
        end
        drain();
        chk("bc_t3", 32'(block_count), 32'(exp_bc));
        // overrun: second result dropped while first is held
        avg_len = 5'd2; avg_shift = 3'd1; bus.out_ready = 1'b0;
        send(16'd10, -16'sd2); send(16'd20, -16'sd2);
        push(1);
        send(16'd100, 16'd7); send(16'd100, 16'd7);
        s_i = 0; s_q = 0; exp_bc++;
        repeat (4) begin @(posedge clk); #1; end
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(bus.out_valid), 32'd1);
        chk("ovr_held", bus.out_data, exp_q[0]);
        chk("bc_t4", 32'(block_count), 32'(exp_bc));
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        bus.out_ready = 1'b1;
        drain();
        // disable discards the partial block
        avg_len = 5'd4; avg_shift = 3'd2;
        send(16'd1000, 16'd1000); send(16'd1000, 16'd1000);
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        s_i = 0; s_q = 0;
        repeat (4) send(16'd4, 16'd8);
        push(2);
        drain();
        chk("bc_t5", 32'(block_count), 32'(exp_bc));
        // length change applies from the next block; block_count wraps here
        avg_shift = 3'd0;
        send(16'd1, 16'd0);
        avg_len = 5'd2;
        send(16'd2, 16'd0); send(16'd3, 16'd0); send(16'd4, 16'd0);
        push(0);
        send(16'd5, 16'd1); send(16'd6, 16'd1);
        push(0);
        drain();
        chk("bc_wrap", 32'(block_count), 32'(exp_bc));
        chk("pre_rst_data", bus.out_data, {16'd2, 16'd11});
        // asynchronous reset mid-block
        send(16'd9, 16'd9);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_data", bus.out_data, 32'd0);
        chk("arst_bc", 32'(block_count), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
